// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues word fetches to a variable-latency
// instruction memory, buffers in-order {pc, instruction} responses and hands
// them to decode over valid/ready. A redirect flushes the queue and restarts
// fetch; responses to requests issued before the redirect are discarded.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [63:0] ins_pc,
  output logic [31:0] instruction
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [63:0]     push_pc_q, push_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [63:0]     pc_mem_q  [DEPTH];
  logic [31:0]     ins_mem_q [DEPTH];

  logic [63:0]     redirect_tgt;
  logic            rvalid_ok;
  logic            resp_drop;
  logic            push;
  logic            pop;
  logic            issue;
  logic [OW-1:0]   inflight_after;

  // Restart address is word aligned; the low two bits are simply masked off.
  assign redirect_tgt   = redirect_pc & ~64'h3;
  // A response with nothing outstanding is spurious and ignored entirely.
  assign rvalid_ok      = mem_rvalid & (outstanding_q != '0);
  assign resp_drop      = rvalid_ok & (redirect | (drop_cnt_q != '0));
  assign push           = rvalid_ok & ~resp_drop;
  assign ins_valid      = (count_q != '0);
  assign pop            = ins_valid & ins_ready;
  // Credit check reserves a queue slot for every in-flight request, so a
  // response can always be accepted and never needs backpressure.
  assign mem_req        = (state_q == FETCH) & ~redirect
                        & (int'(outstanding_q) < MAX_OUT)
                        & ((int'(count_q) + int'(outstanding_q)) < DEPTH);
  assign issue          = mem_req & mem_ready;
  assign mem_addr       = fetch_pc_q;
  assign ins_pc         = ins_valid ? pc_mem_q[rd_ptr_q]  : '0;
  assign instruction    = ins_valid ? ins_mem_q[rd_ptr_q] : '0;
  // Requests still owed by memory after this cycle (no issue under redirect).
  assign inflight_after = outstanding_q - OW'(rvalid_ok);

  // Next-state logic for fetch/push pointers, credits, queue and FSM.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    push_pc_d     = push_pc_q;
    outstanding_d = outstanding_q + OW'(issue) - OW'(rvalid_ok);
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);

    if (issue) fetch_pc_d = fetch_pc_q + 64'd4;
    if (resp_drop && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);
    if (push) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      push_pc_d = push_pc_q + 64'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    // Redirect wins: the pop above has already been presented to decode,
    // then everything queued is thrown away and fetch restarts.
    if (redirect) begin
      fetch_pc_d = redirect_tgt;
      push_pc_d  = redirect_tgt;
      drop_cnt_d = inflight_after;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end

    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (redirect && (inflight_after != '0)) state_d = DRAIN;
      DRAIN:   if (drop_cnt_d == '0) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // State and control registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      push_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      push_pc_q     <= push_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage, written at the tail on every accepted response.
  // NOTE: storage is deliberately not reset; head outputs are forced to zero
  // while the queue is empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= push_pc_q;
      ins_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule
